// File: rtl/hex_char_serializer.sv
// -----------------------------------------------------------------------------
// hex_char_serializer
//
// Purpose:
//   Turns a binary word (typically a 128-bit AES state, key or ciphertext) into
//   a stream of ASCII hexadecimal characters, most-significant nibble first,
//   one character per accepted output transfer. It feeds a UART/console
//   transmitter and is the inverse of the hex-to-binary nibble decoder on the
//   input side of the datapath.
//
// Configuration macro:
//   HEX_CHAR_UPPERCASE_EN  defined   -> nibbles 10..15 encode as 'A'..'F'
//                          undefined -> nibbles 10..15 encode as 'a'..'f'
//   Digits '0'..'9', handshakes and timing are identical in both builds.
//
// Parameters:
//   NIBBLES    hex characters per word (>= 2); in_data is 4*NIBBLES bits wide
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_data    in   binary word to serialize (sampled only on the accept edge)
//   in_valid   in   in_data is valid
//   in_ready   out  block can accept a word (IDLE and not in reset)
//   out_data   out  ASCII character of the current top nibble (8'h00 when idle)
//   out_valid  out  out_data is valid (high for the whole SEND state)
//   out_ready  in   downstream accepts out_data
//   out_last   out  final character of the word
//   busy       out  a word is being serialized
// -----------------------------------------------------------------------------
module hex_char_serializer #(
   parameter int NIBBLES = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4*NIBBLES-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [7:0]           out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 busy
);

   localparam int W     = 4 * NIBBLES;
   localparam int CNT_W = $clog2(NIBBLES);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

`ifdef HEX_CHAR_UPPERCASE_EN
   localparam logic [7:0] ALPHA_BASE = 8'h41;
`else
   localparam logic [7:0] ALPHA_BASE = 8'h61;
`endif

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     shift_q, shift_d;

   // Nibble to ASCII: digits start at '0', letters at the build-selected base.
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      logic [7:0] ch;
      if (nib < 4'd10) begin
         ch = 8'h30 + {4'h0, nib};
      end else begin
         ch = ALPHA_BASE + {4'h0, nib - 4'd10};
      end
      return ch;
   endfunction

   // ---- state register: control is reset, the data shifter is not ----------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end

   // ---- next-state and output decode ---------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_data  = 8'h00;
      busy      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // Ready is masked by rst so nothing is accepted on a reset edge.
            in_ready = ~rst;
            if (in_valid && !rst) begin
               state_d = S_SEND;
               cnt_d   = '0;
               shift_d = in_data;
            end
         end

         S_SEND: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_data  = hex_ascii(shift_q[W-1 -: 4]);
            out_last  = (cnt_q == LAST_IDX);
            if (out_ready) begin
               // The counter never wraps: the last beat leaves SEND instead.
               if (cnt_q == LAST_IDX) begin
                  state_d = S_IDLE;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  shift_d = {shift_q[W-5:0], 4'h0};
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_hex_char_serializer.sv
`timescale 1ns/1ps
module tb_hex_char_serializer;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   out_data;
   logic         out_valid;
   logic         out_ready;
   logic         out_last;
   logic         busy;

   int checks   = 0;
   int failures = 0;

   byte unsigned rx_q[$];
   bit           last_q[$];
   byte unsigned stall_q[$];
   bit           dropout;
   string        hexs;

   always #5 clk = ~clk;

   hex_char_serializer #(.NIBBLES(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy)
   );

   // Reference: character i of a word is the i-th hex digit of its printed form.
   function automatic byte unsigned exp_char(input logic [127:0] w, input int i);
      logic [127:0] t;
      t = w >> (4 * (N - 1 - i));
      return hexs[int'(t[3:0])];
   endfunction

   function automatic logic [127:0] rand_word();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Drives one word through the block and records every handshaked character.
   // mode 0: out_ready high; 1: random out_ready with a 5-cycle stall on char 7;
   // 2: in_data scrambled every cycle during SEND.
   task automatic run_word(input logic [127:0] w, input int mode, input bit keep_valid,
                           input logic [127:0] next_w, input int max_chars,
                           output int wait_cyc, output bit idle_ov, output bit to);
      int n;
      int stall;
      bit stalled;
      bit fin;
      rx_q.delete();
      last_q.delete();
      stall_q.delete();
      dropout  = 1'b0;
      n        = 0;
      stall    = 0;
      stalled  = 1'b0;
      fin      = 1'b0;
      to       = 1'b0;
      wait_cyc = 0;
      in_valid = 1'b1;
      in_data  = w;
      out_ready = 1'b1;
      while (!in_ready && wait_cyc < 100) begin
         @(posedge clk); #1;
         wait_cyc++;
      end
      idle_ov = out_valid;
      if (!in_ready) begin
         to = 1'b1;
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      if (keep_valid) in_data = next_w;
      else in_valid = 1'b0;
      for (int c = 0; c < 400 && !fin && n < max_chars; c++) begin
         if (mode == 2) in_data = rand_word();
         if (mode == 1) begin
            if (stall > 0) begin
               out_ready = 1'b0;
            end else if (n == 6 && !stalled) begin
               stall     = 5;
               stalled   = 1'b1;
               out_ready = 1'b0;
            end else begin
               out_ready = 1'($urandom_range(0, 1));
            end
         end else begin
            out_ready = 1'b1;
         end
         if (stall > 0) begin
            stall_q.push_back(out_data);
            stall--;
         end
         if (out_valid !== 1'b1) dropout = 1'b1;
         if (out_valid === 1'b1 && out_ready) begin
            rx_q.push_back(out_data);
            last_q.push_back(out_last);
            n++;
            if (out_last === 1'b1) fin = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!fin && n < max_chars) to = 1'b1;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = rand_word();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid cyc=%0d got=%b exp=0", i, out_valid); end
         checks++;
         if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
         checks++;
         if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data cyc=%0d got=%h exp=00", i, out_data); end
      end
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL release_busy got=%b exp=0", busy); end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++; $display("FAIL idle_after_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_basic();
      logic [127:0] w;
      int wc;
      bit iov, to;
      w = 128'h00112233445566778899AABBCCDDEEFF;
      run_word(w, 0, 1'b0, '0, N, wc, iov, to);
      checks++;
      if (to) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
      checks++;
      if (rx_q.size() !== N) begin failures++; $display("FAIL basic_len got=%0d exp=%0d", rx_q.size(), N); end
      for (int i = 0; i < rx_q.size() && i < N; i++) begin
         checks++;
         if (rx_q[i] !== exp_char(w, i)) begin failures++; $display("FAIL basic_char i=%0d got=%h exp=%h", i, rx_q[i], exp_char(w, i)); end
         checks++;
         if (last_q[i] !== (i == N - 1)) begin failures++; $display("FAIL basic_last i=%0d got=%b exp=%b", i, last_q[i], (i == N - 1)); end
      end
      checks++;
      if (dropout) begin failures++; $display("FAIL basic_valid_gap got=1 exp=0"); end
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL basic_done in_ready=%b busy=%b exp 1/0", in_ready, busy);
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] w;
      int wc;
      bit iov, to;
      for (int k = 0; k < 4; k++) begin
         w = (k == 0) ? 128'h0123456789ABCDEF0123456789ABCDEF : rand_word();
         run_word(w, 1, 1'b0, '0, N, wc, iov, to);
         checks++;
         if (to) begin failures++; $display("FAIL bp_timeout word=%0d got=1 exp=0", k); end
         checks++;
         if (rx_q.size() !== N) begin failures++; $display("FAIL bp_len word=%0d got=%0d exp=%0d", k, rx_q.size(), N); end
         for (int i = 0; i < rx_q.size() && i < N; i++) begin
            checks++;
            if (rx_q[i] !== exp_char(w, i) || last_q[i] !== (i == N - 1)) begin
               failures++;
               $display("FAIL bp_char word=%0d i=%0d got=%h/%b exp=%h/%b", k, i, rx_q[i], last_q[i], exp_char(w, i), (i == N - 1));
            end
         end
         checks++;
         if (dropout) begin failures++; $display("FAIL bp_valid_gap word=%0d got=1 exp=0", k); end
         checks++;
         if (stall_q.size() !== 5) begin failures++; $display("FAIL bp_stall_len word=%0d got=%0d exp=5", k, stall_q.size()); end
         for (int i = 0; i < stall_q.size(); i++) begin
            checks++;
            if (stall_q[i] !== exp_char(w, 6)) begin
               failures++; $display("FAIL bp_stall_hold word=%0d cyc=%0d got=%h exp=%h", k, i, stall_q[i], exp_char(w, 6));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] w1, w2;
      int wc;
      bit iov, to;
      w1 = '1;
      w2 = '0;
      run_word(w1, 0, 1'b1, w2, N, wc, iov, to);
      checks++;
      if (to || rx_q.size() !== N) begin failures++; $display("FAIL b2b_first_len got=%0d exp=%0d", rx_q.size(), N); end
      for (int i = 0; i < rx_q.size() && i < N; i++) begin
         checks++;
         if (rx_q[i] !== exp_char(w1, i) || last_q[i] !== (i == N - 1)) begin
            failures++; $display("FAIL b2b_first_char i=%0d got=%h/%b exp=%h/%b", i, rx_q[i], last_q[i], exp_char(w1, i), (i == N - 1));
         end
      end
      run_word(w2, 0, 1'b0, '0, N, wc, iov, to);
      checks++;
      if (wc !== 0 || iov !== 1'b0) begin
         failures++; $display("FAIL b2b_idle_gap wait=%0d out_valid=%b exp 0/0", wc, iov);
      end
      checks++;
      if (to || rx_q.size() !== N) begin failures++; $display("FAIL b2b_second_len got=%0d exp=%0d", rx_q.size(), N); end
      for (int i = 0; i < rx_q.size() && i < N; i++) begin
         checks++;
         if (rx_q[i] !== 8'h30 || last_q[i] !== (i == N - 1)) begin
            failures++; $display("FAIL b2b_second_char i=%0d got=%h/%b exp=30/%b", i, rx_q[i], last_q[i], (i == N - 1));
         end
      end
   endtask

   task automatic test_reset_mid_word();
      logic [127:0] w;
      int wc;
      bit iov, to;
      w = rand_word();
      run_word(w, 0, 1'b0, '0, 10, wc, iov, to);
      checks++;
      if (to || rx_q.size() !== 10) begin failures++; $display("FAIL mid_prefix_len got=%0d exp=10", rx_q.size()); end
      for (int i = 0; i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_char(w, i) || last_q[i] !== 1'b0) begin
            failures++; $display("FAIL mid_prefix_char i=%0d got=%h/%b exp=%h/0", i, rx_q[i], last_q[i], exp_char(w, i));
         end
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL mid_reset_abort out_valid=%b out_last=%b busy=%b exp 0/0/0", out_valid, out_last, busy);
      end
      rst = 1'b0;
      w = 128'hDEADBEEF0BADF00DCAFEBABE12345678;
      run_word(w, 0, 1'b0, '0, N, wc, iov, to);
      checks++;
      if (to || rx_q.size() !== N) begin failures++; $display("FAIL mid_next_len got=%0d exp=%0d", rx_q.size(), N); end
      for (int i = 0; i < rx_q.size() && i < N; i++) begin
         checks++;
         if (rx_q[i] !== exp_char(w, i) || last_q[i] !== (i == N - 1)) begin
            failures++; $display("FAIL mid_next_char i=%0d got=%h/%b exp=%h/%b", i, rx_q[i], last_q[i], exp_char(w, i), (i == N - 1));
         end
      end
   endtask

   task automatic test_isolation();
      logic [127:0] w;
      int wc;
      bit iov, to;
      for (int k = 0; k < 2; k++) begin
         w = rand_word();
         run_word(w, 2, 1'b0, '0, N, wc, iov, to);
         checks++;
         if (to || rx_q.size() !== N) begin failures++; $display("FAIL iso_len word=%0d got=%0d exp=%0d", k, rx_q.size(), N); end
         for (int i = 0; i < rx_q.size() && i < N; i++) begin
            checks++;
            if (rx_q[i] !== exp_char(w, i) || last_q[i] !== (i == N - 1)) begin
               failures++; $display("FAIL iso_char word=%0d i=%0d got=%h/%b exp=%h/%b", k, i, rx_q[i], last_q[i], exp_char(w, i), (i == N - 1));
            end
         end
      end
   endtask

   initial begin
`ifdef HEX_CHAR_UPPERCASE_EN
      hexs = "0123456789ABCDEF";
`else
      hexs = "0123456789abcdef";
`endif
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = '0;
      out_ready = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_word();
      test_isolation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
